// File: rtl/alu_ram_pkg.sv
// Shared types for the accumulator CPU datapath: ALU opcodes, ALU width and flag bit positions.
// Pure definitions, no logic.
package alu_ram_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        NOT = 3'b100,
        XOR = 3'b101,
        SHL = 3'b110,
        SHR = 3'b111
    } alu_op_t;

    // alu_flags bit order is {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_arith(input alu_op_t op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/alu16_unit.sv
// Combinational 16-bit ALU with optional {Z,N,C,V} flag generation (ALU_FLAGS_EN).
// Latency: zero cycles, result follows operands in the same cycle.
// Backpressure: none, pure combinational function of its inputs.
module alu16_unit import alu_ram_pkg::*; (
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  alu_op_t          op,
    output logic [ALU_W-1:0] y
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            AND:     y = a & b;
            OR:      y = a | b;
            NOT:     y = ~a;
            XOR:     y = a ^ b;
            SHL:     y = a << 1;
            SHR:     y = a >> 1;
            default: y = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic carry;
    logic ovf;

    // Carry/overflow derived from operand and result sign bits, so no 17-bit adder is needed.
    always_comb begin
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ADD: begin
                carry = (a[ALU_W-1] & b[ALU_W-1]) | ((a[ALU_W-1] | b[ALU_W-1]) & ~y[ALU_W-1]);
                ovf   = (a[ALU_W-1] == b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
            end
            SUB: begin
                carry = (a >= b);
                ovf   = (a[ALU_W-1] != b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
            end
            SHL:     carry = a[ALU_W-1];
            SHR:     carry = a[0];
            default: carry = 1'b0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (y == '0);
        flags[FLAG_N] = y[ALU_W-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = is_arith(op) & ovf;
    end
`endif

endmodule

// File: rtl/alu_ram_core.sv
// Accumulator CPU datapath: word RAM on a shared tri-state bus plus 16-bit ALU; ALU_FLAGS_EN adds registered flags.
// Latency: RAM write on rising edge, RAM read and ALU result combinational; flags one cycle after operands.
// Backpressure: none, the sequencer owns every access cycle and the bus is released whenever not reading.
module alu_ram_core import alu_ram_pkg::*; #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  chip_select_in,
    input  logic                  write_enable,
    input  logic                  output_enable,
    input  logic [ALU_W-1:0]      alu_a,
    input  logic [ALU_W-1:0]      alu_b,
    input  logic [2:0]            alu_sel,
    output logic [ALU_W-1:0]      alu_out
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]            alu_flags
`endif
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];
    logic [ADDR_WIDTH-2:0] word_idx;
    logic                  wr_en;
    logic                  rd_en;
    wire                   unused_addr_lsb = addr[0];

    assign word_idx = addr[ADDR_WIDTH-1:1];
    assign wr_en    = !rst && chip_select_in && write_enable;
    // Write has priority over output_enable so the bus is never driven from both ends.
    assign rd_en    = !rst && chip_select_in && output_enable && !write_enable;

    // Contents survive reset; reset only blocks the write strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_idx] <= data;
        end
    end

    assign data = rd_en ? mem[word_idx] : {DATA_WIDTH{1'bz}};

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_nxt;

    alu16_unit u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .op    (alu_op_t'(alu_sel)),
        .y     (alu_out),
        .flags (flags_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_flags <= '0;
        end else begin
            alu_flags <= flags_nxt;
        end
    end
`else
    alu16_unit u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op_t'(alu_sel)),
        .y  (alu_out)
    );
`endif

endmodule

// File: tb/tb_alu_ram_core.sv
// Scoreboard bench for alu_ram_core: RAM write/read, bus release, reset suppression, ALU vectors
// and, when ALU_FLAGS_EN is defined, registered flags.
module tb_alu_ram_core;
    import alu_ram_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          cs;
    logic          we;
    logic          oe;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [2:0]    sel;
    logic [15:0]   y;
`ifdef ALU_FLAGS_EN
    logic [3:0]    flags;
`endif

    wire  [DW-1:0] data;
    logic          drv_en;
    logic [DW-1:0] drv_dat;

    assign data = drv_en ? drv_dat : {DW{1'bz}};

    always #5 clk = ~clk;

    alu_ram_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .data           (data),
        .chip_select_in (cs),
        .write_enable   (we),
        .output_enable  (oe),
        .alu_a          (a),
        .alu_b          (b),
        .alu_sel        (sel),
        .alu_out        (y)
`ifdef ALU_FLAGS_EN
        ,
        .alu_flags      (flags)
`endif
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  sel;
        logic [15:0] y;
        logic [3:0]  f;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [0:2047];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [15:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got %h expected no output", got);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic ram_write(input logic [AW-1:0] ad, input logic [15:0] d,
                             input logic c, input logic o);
        addr    = ad;
        drv_dat = d;
        drv_en  = 1'b1;
        cs      = c;
        we      = 1'b1;
        oe      = o;
        @(posedge clk);
        #1;
        if (c && !rst) ref_mem[ad[AW-1:1]] = d;
        drv_en = 1'b0;
        cs     = 1'b0;
        we     = 1'b0;
        oe     = 1'b0;
    endtask

    task automatic ram_read(input logic [AW-1:0] ad);
        addr   = ad;
        cs     = 1'b1;
        we     = 1'b0;
        oe     = 1'b1;
        drv_en = 1'b0;
        expect_val($sformatf("rd_%h", ad), ref_mem[ad[AW-1:1]]);
        @(negedge clk);
        sb_check(data);
        @(posedge clk);
        #1;
        cs = 1'b0;
        oe = 1'b0;
    endtask

    // An undriven bus reads as z (4-state) or 0 (2-state); both count as released.
    task automatic bus_released(input string tag, input logic [AW-1:0] ad,
                                input logic c, input logic o);
        logic [15:0] obs;
        addr   = ad;
        cs     = c;
        we     = 1'b0;
        oe     = o;
        drv_en = 1'b0;
        expect_val(tag, 16'h0000);
        @(negedge clk);
        obs = (data === {DW{1'bz}}) ? 16'h0000 : data;
        sb_check(obs);
        @(posedge clk);
        #1;
        cs = 1'b0;
        oe = 1'b0;
    endtask

    task automatic alu_run(input vec_t v, input int idx);
        a   = v.a;
        b   = v.b;
        sel = v.sel;
        expect_val($sformatf("alu_y_%0d", idx), v.y);
`ifdef ALU_FLAGS_EN
        expect_val($sformatf("alu_flags_%0d", idx), {12'h000, v.f});
`endif
        @(negedge clk);
        sb_check(y);
        @(posedge clk);
        #1;
`ifdef ALU_FLAGS_EN
        sb_check({12'h000, flags});
`endif
    endtask

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] f0;
        logic [15:0] f1;
        logic [15:0] fn;

        vecs[0]  = '{16'h0001, 16'h0001, ADD, 16'h0002, 4'b0000};
        vecs[1]  = '{16'hFFFF, 16'h0001, ADD, 16'h0000, 4'b1010};
        vecs[2]  = '{16'h0001, 16'h0002, SUB, 16'hFFFF, 4'b0100};
        vecs[3]  = '{16'h00FF, 16'h1234, NOT, 16'hFF00, 4'b0100};
        vecs[4]  = '{16'hF0F0, 16'h0FF0, AND, 16'h00F0, 4'b0000};
        vecs[5]  = '{16'hF000, 16'h000F, OR,  16'hF00F, 4'b0100};
        vecs[6]  = '{16'h8001, 16'h0000, SHL, 16'h0002, 4'b0010};
        vecs[7]  = '{16'h8001, 16'h0000, SHR, 16'h4000, 4'b0010};
        vecs[8]  = '{16'h7FFF, 16'h0001, ADD, 16'h8000, 4'b0101};
        vecs[9]  = '{16'h8000, 16'h0001, SUB, 16'h7FFF, 4'b0011};
        vecs[10] = '{16'hAAAA, 16'hFFFF, XOR, 16'h5555, 4'b0000};
        vecs[11] = '{16'h0005, 16'h0005, SUB, 16'h0000, 4'b1010};

        rst     = 1'b1;
        addr    = '0;
        cs      = 1'b0;
        we      = 1'b0;
        oe      = 1'b0;
        drv_en  = 1'b0;
        drv_dat = '0;
        a       = '0;
        b       = '0;
        sel     = '0;
        repeat (2) @(posedge clk);
        #1;
`ifdef ALU_FLAGS_EN
        expect_val("flags_reset", 16'h0000);
        sb_check({12'h000, flags});
`endif
        rst = 1'b0;

        ram_write(12'h100, 16'h111C, 1'b1, 1'b0);
        ram_write(12'h122, 16'hFFFF, 1'b1, 1'b0);
        ram_read(12'h100);
        ram_read(12'h122);
        ram_read(12'h123);

        f0 = 16'd1;
        f1 = 16'd1;
        for (int i = 1; i <= 16; i++) begin
            fn = (i <= 2) ? 16'd1 : f0 + f1;
            if (i > 2) begin
                f0 = f1;
                f1 = fn;
            end
            ram_write(AW'(12'h100 + 2 * i), fn, 1'b1, (i == 5));
            if (i == 3) ram_write(AW'(12'h100 + 2 * i), fn, 1'b1, 1'b0);
        end

        ram_write(12'h11E, 16'h1234, 1'b0, 1'b0);
        bus_released("bus_cs_low", 12'h11E, 1'b0, 1'b1);
        bus_released("bus_oe_low", 12'h11E, 1'b1, 1'b0);

        for (int i = 0; i <= 17; i++) begin
            ram_read(AW'(12'h100 + 2 * i));
        end

        for (int i = 0; i < 12; i++) begin
            alu_run(vecs[i], i);
        end

        rst = 1'b1;
        ram_write(12'h104, 16'hBEEF, 1'b1, 1'b0);
`ifdef ALU_FLAGS_EN
        expect_val("flags_midrun_reset", 16'h0000);
        sb_check({12'h000, flags});
`endif
        bus_released("bus_in_reset", 12'h100, 1'b1, 1'b1);
        rst = 1'b0;
        ram_read(12'h104);
        ram_write(12'h104, 16'hBEEF, 1'b1, 1'b0);
        ram_read(12'h104);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
